// File: rtl/synth_pkg.sv
// Shared types and helpers for the tone synthesizer.
//   env_state_e : envelope FSM state (IDLE, ATTACK, SUSTAIN, RELEASE)
//   env_max()   : full-scale envelope level for a given level width
package synth_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_e;

    localparam int unsigned ENV_WIDTH_DEF = 8;

    // ENV_MAX = 2^w - 1
    function automatic int unsigned env_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/tone_envelope.sv
// Linear attack/release envelope and phase-increment holder.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : sample strobe; all updates happen only when high
//   fstep      : requested phase increment, 0 = silence
//   inc        : registered phase increment in use
//   state      : registered envelope state
//   state_nxt  : state after the current tick (equals state when no tick)
//   env_nxt    : envelope level after the current tick
module tone_envelope
    import synth_pkg::*;
#(
    parameter int unsigned env_width_p = ENV_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic [31:0]            fstep,
    output logic [31:0]            inc,
    output env_state_e             state,
    output env_state_e             state_nxt,
    output logic [env_width_p-1:0] env_nxt
);

    localparam logic [env_width_p-1:0] ENV_MAX = env_width_p'(env_max(env_width_p));

    logic [env_width_p-1:0] env;
    logic [31:0]            inc_nxt;

    // Next values are exported so the top can build the sample from the
    // post-update envelope on the same tick edge.
    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        inc_nxt   = inc;
        if (tick) begin
            case (state)
                IDLE: begin
                    env_nxt = '0;
                    if (fstep != '0) begin
                        inc_nxt   = fstep;
                        state_nxt = ATTACK;
                    end
                end
                ATTACK: begin
                    if (fstep == '0) begin
                        state_nxt = RELEASE;
                    end else begin
                        inc_nxt = fstep;
                        if (env >= ENV_MAX - 1'b1) begin
                            env_nxt   = ENV_MAX;
                            state_nxt = SUSTAIN;
                        end else begin
                            env_nxt = env + 1'b1;
                        end
                    end
                end
                SUSTAIN: begin
                    if (fstep == '0) begin
                        state_nxt = RELEASE;
                    end else begin
                        inc_nxt = fstep;
                    end
                end
                RELEASE: begin
                    if (fstep != '0) begin
                        // resume attack from the current level
                        inc_nxt   = fstep;
                        state_nxt = ATTACK;
                    end else if (env <= env_width_p'(1)) begin
                        env_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        env_nxt = env - 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            env   <= '0;
            inc   <= '0;
        end else begin
            state <= state_nxt;
            env   <= env_nxt;
            inc   <= inc_nxt;
        end
    end

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone synthesizer with attack/release envelope.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   fstep_i         : phase increment per sample, 0 = silence request
//   sample_o        : signed audio sample
//   valid_o         : sample_o holds an unconsumed sample
//   ready_i         : downstream accepts when valid_o & ready_i
//   busy_o          : envelope is not idle
//   overrun_o       : one-cycle pulse when a new sample was dropped
module tone_synth
    import synth_pkg::*;
#(
    parameter int unsigned sample_div_p = 520,
    parameter int unsigned width_p      = 24,
    parameter int unsigned env_width_p  = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [31:0]               fstep_i,
    output logic signed [width_p-1:0] sample_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      busy_o,
    output logic                      overrun_o
);

    localparam int unsigned          DIV_W    = $clog2(sample_div_p);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(sample_div_p - 1);
    localparam int unsigned          SHIFT    = width_p - env_width_p - 2;

    logic [DIV_W-1:0]        div;
    logic                    tick;
    logic [31:0]             phase;
    logic [31:0]             phase_nxt;
    logic [31:0]             inc;
    env_state_e              state;
    env_state_e              state_nxt;
    logic [env_width_p-1:0]  env_nxt;
    logic [width_p-1:0]      mag;
    logic [width_p-1:0]      sample_nxt;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    tone_envelope #(
        .env_width_p(env_width_p)
    ) u_envelope (
        .clk       (clk_i),
        .rst_n     (reset_ni),
        .tick      (tick),
        .fstep     (fstep_i),
        .inc       (inc),
        .state     (state),
        .state_nxt (state_nxt),
        .env_nxt   (env_nxt)
    );

    // Phase is pinned to 0 while idle and cleared on entry to idle;
    // otherwise it advances by the increment held before this tick.
    always_comb begin
        if (state == IDLE || state_nxt == IDLE) begin
            phase_nxt = '0;
        end else begin
            phase_nxt = phase + inc;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            phase <= '0;
        end else if (tick) begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        mag = width_p'(env_nxt) << SHIFT;
        if (state_nxt == IDLE) begin
            sample_nxt = '0;
        end else if (phase_nxt[31]) begin
            sample_nxt = -mag;
        end else begin
            sample_nxt = mag;
        end
    end

    // A stalled sample is kept and the fresh one dropped.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sample_o  <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (tick) begin
                if (valid_o && !ready_i) begin
                    overrun_o <= 1'b1;
                end else begin
                    sample_o <= sample_nxt;
                    valid_o  <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_tone_synth.sv
// Self-checking bench for tone_synth against an arithmetic reference model.
module tb_tone_synth;

    localparam int DIV     = 4;
    localparam int W       = 24;
    localparam int EW      = 8;
    localparam int ENV_MAX = (1 << EW) - 1;
    localparam int STEP    = 1 << (W - EW - 2);

    logic                clk = 1'b0;
    logic                reset_ni;
    logic [31:0]         fstep_i;
    logic signed [W-1:0] sample_o;
    logic                valid_o;
    logic                ready_i;
    logic                busy_o;
    logic                overrun_o;

    always #5 clk = ~clk;

    tone_synth #(
        .sample_div_p(DIV),
        .width_p     (W),
        .env_width_p (EW)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .fstep_i  (fstep_i),
        .sample_o (sample_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .busy_o   (busy_o),
        .overrun_o(overrun_o)
    );

    int n_total = 0;
    int n_pass  = 0;

    // reference model: note on/off, level direction (+1 up, 0 hold, -1 down)
    int          m_div;
    bit          m_on;
    int          m_dir;
    int          m_env;
    longint      m_phase;
    longint      m_inc;
    logic [W-1:0] m_sample;
    bit          m_valid;
    bit          m_ovr;
    int          ov_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_div = 0; m_on = 0; m_dir = 0; m_env = 0;
        m_phase = 0; m_inc = 0;
        m_sample = '0; m_valid = 0; m_ovr = 0;
    endtask

    function automatic logic [W-1:0] expect_sample();
        int s;
        if (!m_on) return '0;
        s = m_env * STEP;
        if (m_phase >= 64'h8000_0000) s = -s;
        return W'(s);
    endfunction

    function automatic int mag_of(input logic signed [W-1:0] s);
        return (s < 0) ? -int'(s) : int'(s);
    endfunction

    task automatic model_tick(input logic [31:0] f);
        if (!m_on) begin
            if (f != 0) begin
                m_inc = longint'(f); m_on = 1; m_dir = 1;
            end
        end else begin
            m_phase = (m_phase + m_inc) & 64'hFFFF_FFFF;
            if (f == 0) begin
                if (m_dir != -1) begin
                    m_dir = -1;
                end else begin
                    m_env = (m_env > 0) ? m_env - 1 : 0;
                    if (m_env == 0) begin
                        m_on = 0; m_phase = 0; m_dir = 0;
                    end
                end
            end else begin
                m_inc = longint'(f);
                if (m_dir == -1) begin
                    m_dir = 1;
                end else if (m_dir == 1) begin
                    m_env = (m_env < ENV_MAX) ? m_env + 1 : ENV_MAX;
                    if (m_env == ENV_MAX) m_dir = 0;
                end
            end
        end
    endtask

    task automatic model_out(input bit tk, input bit rdy, input logic [W-1:0] s);
        if (tk) begin
            if (m_valid && !rdy) begin
                m_ovr = 1;
            end else begin
                m_sample = s; m_valid = 1; m_ovr = 0;
            end
        end else begin
            m_ovr = 0;
            if (m_valid && rdy) m_valid = 0;
        end
    endtask

    task automatic cyc();
        bit          tk;
        bit          rdy;
        logic [31:0] f;
        @(posedge clk);
        rdy = ready_i;
        f   = fstep_i;
        tk  = (m_div == DIV - 1);
        m_div = tk ? 0 : m_div + 1;
        if (tk) model_tick(f);
        model_out(tk, rdy, expect_sample());
        #1;
        if (overrun_o) ov_seen++;
        check("valid",   32'(valid_o),   32'(m_valid));
        check("sample",  {8'h0, sample_o}, {8'h0, m_sample});
        check("overrun", 32'(overrun_o), 32'(m_ovr));
        check("busy",    32'(busy_o),    32'(m_on));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic align();
        for (int i = 0; i < DIV && m_div != 0; i++) cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a1;
        int          a2;
        logic [W-1:0] held;
        bit          hit;

        reset_ni = 1'b0;
        fstep_i  = '0;
        ready_i  = 1'b1;
        ov_seen  = 0;
        model_reset();

        #12;
        check("rst_sample",  {8'h0, sample_o}, 32'h0);
        check("rst_valid",   32'(valid_o),   32'h0);
        check("rst_busy",    32'(busy_o),    32'h0);
        check("rst_overrun", 32'(overrun_o), 32'h0);
        @(posedge clk); #3;
        reset_ni = 1'b1;

        // idle: zero samples every DIV cycles
        run(16);

        // attack up to sustain
        fstep_i = 32'h4000_0000;
        run(DIV * 258);
        align();
        check("sustain_mag", 32'(mag_of(sample_o)), 32'(255 * STEP));

        // sustain with random increments and random back-pressure
        for (int i = 0; i < 160; i++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) fstep_i = $urandom | 32'h1;
            cyc();
        end
        ready_i = 1'b1;
        run(DIV);
        align();

        // release: level falls one step per sample
        fstep_i = '0;
        run(DIV);
        run(DIV);
        a1 = mag_of(sample_o);
        run(DIV);
        a2 = mag_of(sample_o);
        check("release_step", 32'(a1 - a2), 32'(STEP));

        hit = 0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            cyc();
            hit = (m_dir == -1 && m_env == 100);
        end
        check("reach_env100", 32'(hit), 32'h1);

        // retrigger during release resumes from the current level
        fstep_i = 32'h2000_0000;
        run(DIV);
        run(DIV);
        check("resume_mag", 32'(mag_of(sample_o)), 32'(101 * STEP));
        check("resume_busy", 32'(busy_o), 32'h1);

        // back to sustain, then stall across two ticks
        run(DIV * 160);
        align();
        cyc();
        ready_i = 1'b0;
        ov_seen = 0;
        run(DIV - 1);
        held = sample_o;
        check("stall_loaded", 32'(valid_o), 32'h1);
        run(DIV);
        check("stall_overrun_cnt", 32'(ov_seen), 32'h1);
        check("stall_held", {8'h0, sample_o}, {8'h0, held});
        ready_i = 1'b1;
        cyc();
        check("stall_accept", 32'(valid_o), 32'h0);

        // large increment: phase wraps modulo 2^32
        fstep_i = 32'hC000_0000;
        run(DIV * 8);

        // random notes, rests and back-pressure
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 2))
                    0:       fstep_i = '0;
                    1:       fstep_i = $urandom;
                    default: fstep_i = 32'($urandom_range(1, 255)) << 24;
                endcase
            end
            ready_i = ($urandom_range(0, 4) != 0);
            cyc();
        end

        // asynchronous reset mid-note
        fstep_i = 32'h1000_0000;
        ready_i = 1'b1;
        run(DIV * 10);
        #2;
        reset_ni = 1'b0;
        #1;
        check("arst_sample",  {8'h0, sample_o}, 32'h0);
        check("arst_valid",   32'(valid_o),   32'h0);
        check("arst_busy",    32'(busy_o),    32'h0);
        check("arst_overrun", 32'(overrun_o), 32'h0);
        model_reset();
        #1;
        reset_ni = 1'b1;
        run(DIV - 1);
        check("arst_no_early_tick", 32'(valid_o), 32'h0);
        run(1);
        check("arst_first_tick", 32'(valid_o), 32'h1);
        run(DIV * 6);

        fstep_i = '0;
        run(DIV * 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
